memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute. Performs lw/sw accesses on a req/ack data-memory port.
//  Forwards ALU results of all other opcodes to writeback with 1-cycle latency.
//  Stalls upstream while an access is outstanding, and enforces a bus timeout that faults and halts.
// PARAMETERS
//  TIMEOUT     64   max ACCESS cycles waiting for mem_ack before bus error (>=1)
//  CNT_W       7    timeout counter width; must hold TIMEOUT
// PORTS
//  clk          in   1   system clock, all flops on posedge
//  rst_n        in   1   asynchronous active-low reset
//  bubble_in    in   1   1 = no valid instruction from execute this cycle
//  halt_in      in   1   instruction from execute is a halt
//  opcode_in    in   3   opcode from execute (3'b100 sw, 3'b101 lw)
//  tgt_in       in   3   destination register from execute
//  result_in    in   16  ALU result; the effective address for lw/sw
//  store_data   in   16  forwarded rs2 value for sw
//  stall        out  1   upstream must hold its outputs this cycle
//  mem_req      out  1   data-memory request
//  mem_we       out  1   1 = write (sw), 0 = read (lw); valid with mem_req
//  mem_addr     out  16  access address; valid with mem_req
//  mem_wdata    out  16  write data; valid with mem_req && mem_we
//  mem_rdata    in   16  read data; sampled on the edge where mem_ack=1
//  mem_ack      in   1   access complete this cycle
//  wb_result    out  16  value to write back
//  wb_tgt       out  3   writeback register; 0 = no write; also used for forwarding
//  wb_bubble    out  1   1 = no instruction retiring to writeback
//  wb_halt      out  1   retiring instruction halts the machine
//  bus_err      out  1   sticky bus-timeout flag
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, halted=0, counter=0, bus_err=0, wb_bubble=1,
//   wb_halt=0, wb_tgt=0, wb_result=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   Reset mid-access drops mem_req immediately. A late mem_ack after reset is ignored.
//  valid = !bubble_in && !halted.
//  FSM IDLE:
//   - valid && opcode lw/sw: latch addr/data/we/tgt; go to ACCESS; wb_bubble<=1.
//   - valid && other opcode: wb_result<=result_in, wb_tgt<=tgt_in, wb_bubble<=0, wb_halt<=halt_in.
//   - !valid: wb_bubble<=1, wb_halt<=0.
//  FSM ACCESS:
//   - mem_req=1 (from state flop); mem_addr/mem_we/mem_wdata come from latched registers.
//   - stall=1 for the whole ACCESS state, including the ack cycle. The input is not sampled.
//   - mem_ack: lw sets wb_result<=mem_rdata, wb_tgt<=latched tgt. sw sets wb_tgt<=0.
//     In both cases wb_bubble<=0, wb_halt<=latched halt. Go to IDLE; counter<=0.
//   - no ack: counter++. At counter==TIMEOUT-1 with no ack: bus_err<=1, wb_bubble<=1,
//     wb_halt<=1, halted<=1, go to IDLE.
//   - ack and timeout in the same cycle: ack wins.
//  stall = (state==ACCESS). Combinational from the state flop only; no input-to-stall path.
//  Latency: non-mem op 1 edge. lw/sw 1 + N edges, where N = cycles until ack (min total 2).
//  Halt: a valid halt_in sets halted<=1 on retirement. Afterwards all inputs are bubbles and
//   no new mem_req is issued until reset. bus_err clears only on reset.
//  mem_ack while IDLE is ignored. A tgt_in of 0 passes through unchanged (write suppressed downstream).
//  All arithmetic is 16-bit unsigned. Counter saturates; it never wraps.
// STRUCTURE
//  Shared package (cpu_pkg): OP_SW=3'b100, OP_LW=3'b101, OP_JALR=3'b111; state enum {IDLE, ACCESS}.
//  One sub-module: mem_access_timer (clear/enable/expired, TIMEOUT param, async rst_n).
//  The rest is inline: FSM, latched access registers, and writeback output registers.
// TESTING
//  1. addi retiring: result_in=16'h0042, tgt_in=3 -> next edge wb_result=0042, wb_tgt=3,
//     wb_bubble=0, stall never asserted.
//  2. lw addr 0x0010, ack on 3rd ACCESS cycle, rdata=BEEF -> mem_req/stall high 3 cycles,
//     mem_we=0, mem_addr=0010; then wb_result=BEEF, wb_bubble=0.
//  3. sw addr 0x0020, data 0x1234, ack in first cycle -> mem_we=1, mem_wdata=1234, stall 1 cycle,
//     wb_tgt=0, wb_bubble=0.
//  4. lw with no ack, TIMEOUT=4 -> mem_req high exactly 4 cycles; bus_err=1, wb_halt=1, wb_bubble=1.
//     A later lw issues no mem_req.
//  5. rst_n low during ACCESS cycle 2 -> mem_req=0 at once, all outputs at reset values;
//     after release, lw proceeds normally.
//  6. halt_in on valid op, then lw, spurious mem_ack in IDLE -> wb_halt=1 once;
//     no mem_req, wb outputs unchanged by the ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes and memory-stage FSM states.
package cpu_pkg;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction
endpackage

// File: rtl/mem_access_timer.sv
// Counts ACCESS cycles; expired flags the last allowed cycle. Saturates, never wraps.
module mem_access_timer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: lw/sw over a req/ack port, 1-cycle forwarding for other ops,
// upstream stall while an access is outstanding, and a halting bus timeout.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble_in,
    input  logic        halt_in,
    input  logic [2:0]  opcode_in,
    input  logic [2:0]  tgt_in,
    input  logic [15:0] result_in,
    input  logic [15:0] store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] wb_result,
    output logic [2:0]  wb_tgt,
    output logic        wb_bubble,
    output logic        wb_halt,
    output logic        bus_err
);
    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d, hlt_lat_q, hlt_lat_d;
    logic [2:0]  tgt_lat_q, tgt_lat_d;
    logic [15:0] wb_result_q, wb_result_d;
    logic [2:0]  wb_tgt_q, wb_tgt_d;
    logic        wb_bubble_q, wb_bubble_d, wb_halt_q, wb_halt_d;
    logic        valid, expired, in_access;

    assign valid     = !bubble_in && !halted_q;
    assign in_access = (state_q == ACCESS);

    mem_access_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_access || mem_ack),
        .enable  (in_access),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid && is_mem_op(opcode_in)) state_d = ACCESS;
            ACCESS:  if (mem_ack || expired)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port outputs depend on state flops only, so no input reaches stall combinationally.
    always_comb begin
        stall     = in_access;
        mem_req   = in_access;
        mem_we    = in_access && we_q;
        mem_addr  = in_access ? addr_q : '0;
        mem_wdata = (in_access && we_q) ? wdata_q : '0;
    end

    always_comb begin
        halted_d    = halted_q;
        bus_err_d   = bus_err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        tgt_lat_d   = tgt_lat_q;
        hlt_lat_d   = hlt_lat_q;
        wb_result_d = wb_result_q;
        wb_tgt_d    = wb_tgt_q;
        wb_bubble_d = wb_bubble_q;
        wb_halt_d   = wb_halt_q;
        if (!in_access) begin
            if (!valid) begin
                wb_bubble_d = 1'b1;
                wb_halt_d   = 1'b0;
            end else if (is_mem_op(opcode_in)) begin
                addr_d      = result_in;
                wdata_d     = store_data;
                we_d        = (opcode_in == OP_SW);
                tgt_lat_d   = tgt_in;
                hlt_lat_d   = halt_in;
                wb_bubble_d = 1'b1;
                wb_halt_d   = 1'b0;
            end else begin
                wb_result_d = result_in;
                wb_tgt_d    = tgt_in;
                wb_bubble_d = 1'b0;
                wb_halt_d   = halt_in;
                if (halt_in) halted_d = 1'b1;
            end
        end else if (mem_ack) begin
            if (we_q) begin
                wb_tgt_d    = 3'd0;
            end else begin
                wb_result_d = mem_rdata;
                wb_tgt_d    = tgt_lat_q;
            end
            wb_bubble_d = 1'b0;
            wb_halt_d   = hlt_lat_q;
            if (hlt_lat_q) halted_d = 1'b1;
        end else if (expired) begin
            bus_err_d   = 1'b1;
            wb_bubble_d = 1'b1;
            wb_halt_d   = 1'b1;
            halted_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            tgt_lat_q   <= '0;
            hlt_lat_q   <= 1'b0;
            wb_result_q <= '0;
            wb_tgt_q    <= '0;
            wb_bubble_q <= 1'b1;
            wb_halt_q   <= 1'b0;
        end else begin
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            tgt_lat_q   <= tgt_lat_d;
            hlt_lat_q   <= hlt_lat_d;
            wb_result_q <= wb_result_d;
            wb_tgt_q    <= wb_tgt_d;
            wb_bubble_q <= wb_bubble_d;
            wb_halt_q   <= wb_halt_d;
        end
    end

    assign wb_result = wb_result_q;
    assign wb_tgt    = wb_tgt_q;
    assign wb_bubble = wb_bubble_q;
    assign wb_halt   = wb_halt_q;
    assign bus_err   = bus_err_q;
endmodule
